stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer for the Tiny-CPU datapath, the clocked successor of the 8-to-1 byte mux. Each channel has a valid/ready handshake. One channel is granted per cycle, either by an explicit select (fixed mode) or by round-robin arbitration. The granted beat is captured in a one-deep output register. Typical uses are merging several producers (register file read ports, ALU result, immediate path, I/O) onto a single bus with back-pressure.

## Interface
Parameters:
- WIDTH, 8 — data width of each channel and of the output.
- CHANNELS, 8 — number of input channels; legal range 2..16.
- SELW, 3 — select/channel-index width; must equal ceil(log2(CHANNELS)).

Ports:
- Clk  input  1  — single clock; all state updates on the rising edge.
- Reset  input  1  — synchronous, active-high reset.
- Mode  input  1  — 0 = fixed select via Sel; 1 = round-robin.
- Sel  input  SELW  — channel index used when Mode=0.
- In_Data  input  CHANNELS*WIDTH  — channel i occupies bits [i*WIDTH +: WIDTH].
- In_Valid  input  CHANNELS  — per-channel beat valid.
- In_Ready  output  CHANNELS  — per-channel accept; at most one bit set.
- Y  output  WIDTH  — registered output data.
- Y_Valid  output  1  — output register holds a beat.
- Y_Ready  input  1  — downstream accepts Y this cycle.
- Y_Chan  output  SELW  — source channel index of the beat in Y.

## Operation
- Stall condition: Load = ~Y_Valid | Y_Ready. When Load=0, all In_Ready are 0 and nothing moves.
- Grant (combinational):
  - Mode=0: grant Sel if Sel < CHANNELS and In_Valid[Sel]; otherwise no grant. A Sel value at or above CHANNELS never grants.
  - Mode=1: the first i with In_Valid[i], searching Ptr, Ptr+1, …, CHANNELS-1, 0, …, Ptr-1.
- In_Ready[g] = Load & grant valid & ~Reset. A transfer occurs when In_Valid[g] & In_Ready[g].
- On a transfer: Y <= beat, Y_Chan <= g, Y_Valid <= 1, Ptr <= (g+1) mod CHANNELS. Ptr wraps from CHANNELS-1 to 0.
- Load=1 with no transfer: Y_Valid <= 0 (drain). Y and Y_Chan hold their last values.
- Load=0: Y, Y_Chan and Y_Valid hold.
- Ptr advances only on a transfer, in either mode. A fixed-mode transfer therefore also moves Ptr.
- Mode and Sel are sampled every cycle. A change affects only the next grant, never the beat already in the output register.
- Data never changes while Y_Valid=1 and Y_Ready=0.

## Timing
- Reset values: Y=0, Y_Valid=0, Y_Chan=0, Ptr=0, lock state cleared, In_Ready=0 while Reset is high.
- Reset asserted mid-operation discards the held beat in the next cycle. No input transfer occurs in a cycle where Reset=1.
- Latency: one cycle from transfer to Y_Valid.
- Throughput: one beat per cycle when Y_Ready is held at 1.
- Simultaneous output drain and input accept in the same cycle is allowed and produces no bubble.
- In_Ready depends combinationally on In_Valid, Mode, Sel and Y_Ready. Upstream In_Valid must not depend on In_Ready.

## Configuration
- STREAM_MUX_RR_LOCK_EN defined:
  - Adds ports In_Last (input, CHANNELS) and Y_Last (output, 1, reset 0).
  - Y_Last is registered alongside Y.
  - After a transfer with In_Last[g]=0, the grant is locked to g in both modes, ignoring Sel and Ptr, until a transfer from g with In_Last[g]=1.
  - Ptr updates only on that final beat.
  - Reset clears the lock.
- STREAM_MUX_RR_LOCK_EN undefined: these ports are absent and arbitration is per beat as described above.

## Test plan
- Reset with In_Valid=8'hFF, Mode=1 -> In_Ready=0 throughout reset. First cycle after reset grants channel 0. Y_Valid=0 and Y=0 during reset.
- Mode=1, all channels valid, channel i data = 8'h10+i, Y_Ready=1 -> Y sequence 10,11,…,17,10. Y_Chan tracks the sequence and wraps 7->0. No bubbles.
- Mode=0, Sel=5, In_Valid=8'b0010_0000, Y_Ready=0 for 3 cycles -> one beat captured. In_Ready[5]=0 while stalled. Y stays 8'h15 until Y_Ready=1.
- CHANNELS=6, SELW=3, Mode=0, Sel=7 with all valid -> no In_Ready asserted, Y_Valid stays 0.
- Mode=1, Ptr=3, In_Valid=8'b0000_0101 -> grants channel 0 then 2. Reset asserted while Y_Valid=1 -> Y_Valid=0 next cycle.
- With STREAM_MUX_RR_LOCK_EN: channel 2 sends 3 beats (last on the third) while channel 3 is valid -> channel 3 is granted only after Y_Last=1 from channel 2.

Source files
------------

// File: rtl/stream_mux_rr.sv
// Clocked N-channel stream multiplexer with fixed-select or round-robin grant
// and a one-deep output register. Packet locking via STREAM_MUX_RR_LOCK_EN.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SELW     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [SELW-1:0]           y_chan
`ifdef STREAM_MUX_RR_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      y_last
`endif
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  ptr_next;
    logic [SELW-1:0]  idx;
    logic [WIDTH-1:0] beat;
    logic             gnt_valid;
    logic             load;
    logic             xfer;
    int               j;

`ifdef STREAM_MUX_RR_LOCK_EN
    logic             lock_active;
    logic [SELW-1:0]  lock_chan;
`endif

    // The output register can take a new beat when empty or being drained.
    assign load = ~y_valid | y_ready;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        j         = 0;
        if (mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                j = int'(ptr) + k;
                if (j >= CHANNELS) j = j - CHANNELS;
                idx = SELW'(j);
                if (!gnt_valid && in_valid[idx]) begin
                    gnt       = idx;
                    gnt_valid = 1'b1;
                end
            end
        end else if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
            gnt       = sel;
            gnt_valid = 1'b1;
        end
`ifdef STREAM_MUX_RR_LOCK_EN
        // An open packet pins the grant regardless of mode, sel and ptr.
        if (lock_active) begin
            gnt       = lock_chan;
            gnt_valid = in_valid[lock_chan];
        end
`endif
    end

    assign xfer     = load & gnt_valid & ~reset;
    assign ptr_next = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + SELW'(1);

    always_comb begin
        in_ready = '0;
        beat     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt == SELW'(i)) begin
                in_ready[i] = xfer;
                beat        = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_chan  <= '0;
`ifdef STREAM_MUX_RR_LOCK_EN
            y_last  <= 1'b0;
`endif
        end else if (load) begin
            if (xfer) begin
                y       <= beat;
                y_chan  <= gnt;
                y_valid <= 1'b1;
`ifdef STREAM_MUX_RR_LOCK_EN
                y_last  <= in_last[gnt];
`endif
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_RR_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            lock_active <= 1'b0;
            lock_chan   <= '0;
        end else if (xfer) begin
            if (in_last[gnt]) begin
                ptr         <= ptr_next;
                lock_active <= 1'b0;
            end else begin
                lock_active <= 1'b1;
                lock_chan   <= gnt;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= ptr_next;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel instance for the main
// scenarios and a 6-channel instance for out-of-range select and wrap.
module tb_stream_mux_rr;

    logic        clk;
    logic        reset;

    logic        mode;
    logic [2:0]  sel;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [2:0]  y_chan;
    logic [7:0]  in_last;
`ifdef STREAM_MUX_RR_LOCK_EN
    logic        y_last;
`endif

    logic        mode6;
    logic [2:0]  sel6;
    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [7:0]  y6;
    logic        y_valid6;
    logic        y_ready6;
    logic [2:0]  y_chan6;
    logic [5:0]  in_last6;
`ifdef STREAM_MUX_RR_LOCK_EN
    logic        y_last6;
`endif

    int n_checks;
    int n_fail;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(8), .SELW(3)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_chan   (y_chan)
`ifdef STREAM_MUX_RR_LOCK_EN
        ,
        .in_last  (in_last),
        .y_last   (y_last)
`endif
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(6), .SELW(3)) u_dut6 (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode6),
        .sel      (sel6),
        .in_data  (in_data6),
        .in_valid (in_valid6),
        .in_ready (in_ready6),
        .y        (y6),
        .y_valid  (y_valid6),
        .y_ready  (y_ready6),
        .y_chan   (y_chan6)
`ifdef STREAM_MUX_RR_LOCK_EN
        ,
        .in_last  (in_last6),
        .y_last   (y_last6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        reset    = 1'b1;
        mode     = 1'b1;
        sel      = 3'd0;
        in_valid = 8'hFF;
        y_ready  = 1'b1;
        in_last  = 8'hFF;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);

        mode6     = 1'b0;
        sel6      = 3'd7;
        in_valid6 = 6'h3F;
        y_ready6  = 1'b1;
        in_last6  = 6'h3F;
        for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'(8'h20 + i);

        // Reset with every channel requesting.
        step();
        check("rst_in_ready", 32'(in_ready), 32'h00);
        check("rst_y_valid", 32'(y_valid), 32'h0);
        check("rst_y", 32'(y), 32'h00);
        check("rst_y_chan", 32'(y_chan), 32'h0);
        step();
        check("rst_in_ready2", 32'(in_ready), 32'h00);

        reset = 1'b0;
        #1;
        check("first_grant", 32'(in_ready), 32'h01);

        // Round-robin over all channels with wrap, one beat per cycle.
        for (int k = 0; k < 9; k++) begin
            step();
            check("rr_y_valid", 32'(y_valid), 32'h1);
            check("rr_y", 32'(y), 32'(8'h10 + (k % 8)));
            check("rr_y_chan", 32'(y_chan), 32'(k % 8));
        end

        // Drain: register empties, data and channel hold.
        in_valid = 8'h00;
        step();
        check("drain_y_valid", 32'(y_valid), 32'h0);
        check("drain_y_hold", 32'(y), 32'h10);
        check("drain_chan_hold", 32'(y_chan), 32'h0);

        // Fixed select with downstream stall.
        mode     = 1'b0;
        sel      = 3'd5;
        in_valid = 8'b0010_0000;
        y_ready  = 1'b0;
        #1;
        check("fix_in_ready", 32'(in_ready), 32'h20);
        step();
        check("fix_y", 32'(y), 32'h15);
        check("fix_y_chan", 32'(y_chan), 32'h5);
        check("fix_stall_ready", 32'(in_ready), 32'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_y", 32'(y), 32'h15);
            check("stall_y_valid", 32'(y_valid), 32'h1);
            check("stall_in_ready", 32'(in_ready), 32'h00);
        end
        y_ready  = 1'b1;
        in_valid = 8'h00;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h00);
        step();
        check("release_y_valid", 32'(y_valid), 32'h0);

        // Fixed transfer from channel 2 moves ptr to 3.
        sel      = 3'd2;
        in_valid = 8'h04;
        #1;
        check("fix2_in_ready", 32'(in_ready), 32'h04);
        step();
        check("fix2_y", 32'(y), 32'h12);

        // Round-robin from ptr=3 with channels 0 and 2 valid.
        mode     = 1'b1;
        in_valid = 8'b0000_0101;
        #1;
        check("rr3_grant0", 32'(in_ready), 32'h01);
        step();
        check("rr3_y0", 32'(y_chan), 32'h0);
        check("rr3_grant2", 32'(in_ready), 32'h04);
        step();
        check("rr3_y2", 32'(y_chan), 32'h2);
        check("rr3_y2_valid", 32'(y_valid), 32'h1);

        // Reset while holding a beat discards it.
        y_ready  = 1'b0;
        in_valid = 8'h00;
        reset    = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'h00);
        step();
        check("midrst_y_valid", 32'(y_valid), 32'h0);
        check("midrst_y", 32'(y), 32'h00);
        reset   = 1'b0;
        y_ready = 1'b1;

        // Six-channel instance: select values at or above CHANNELS never grant.
        #1;
        check("c6_sel7_ready", 32'(in_ready6), 32'h00);
        check("c6_sel7_y_valid", 32'(y_valid6), 32'h0);
        sel6 = 3'd6;
        #1;
        check("c6_sel6_ready", 32'(in_ready6), 32'h00);
        step();
        check("c6_sel6_y_valid", 32'(y_valid6), 32'h0);
        sel6 = 3'd5;
        #1;
        check("c6_sel5_ready", 32'(in_ready6), 32'h20);
        step();
        check("c6_sel5_y", 32'(y6), 32'h25);
        check("c6_sel5_chan", 32'(y_chan6), 32'h5);
        mode6 = 1'b1;
        #1;
        check("c6_wrap_ready", 32'(in_ready6), 32'h01);
        step();
        check("c6_wrap_y", 32'(y6), 32'h20);
        check("c6_wrap_chan", 32'(y_chan6), 32'h0);

`ifdef STREAM_MUX_RR_LOCK_EN
        // Single-beat packet from channel 2 sets ptr to 3.
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 8'h04;
        in_last  = 8'h04;
        step();
        check("lk_pre_chan", 32'(y_chan), 32'h2);
        check("lk_pre_last", 32'(y_last), 32'h1);

        // Three-beat packet from channel 2 while channel 3 waits.
        in_valid = 8'h0C;
        in_last  = 8'h00;
        #1;
        check("lk_b0_ready", 32'(in_ready), 32'h04);
        step();
        check("lk_b0_chan", 32'(y_chan), 32'h2);
        check("lk_b0_last", 32'(y_last), 32'h0);
        mode = 1'b1;
        #1;
        check("lk_b1_ready", 32'(in_ready), 32'h04);
        step();
        check("lk_b1_chan", 32'(y_chan), 32'h2);
        check("lk_b1_last", 32'(y_last), 32'h0);
        in_last = 8'h04;
        #1;
        check("lk_b2_ready", 32'(in_ready), 32'h04);
        step();
        check("lk_b2_chan", 32'(y_chan), 32'h2);
        check("lk_b2_last", 32'(y_last), 32'h1);
        check("lk_ch3_ready", 32'(in_ready), 32'h08);
        step();
        check("lk_ch3_chan", 32'(y_chan), 32'h3);
        check("lk_ch3_y", 32'(y), 32'h13);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
